// File: rtl/dti_uart_pkg.sv
// dti_uart_pkg: shared types and constants
// for the UART transmit and receive blocks.
package dti_uart_pkg;

  localparam int OVS       = 16;
  localparam int DIV_W_DEF = 16;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  function automatic logic [7:0] len_mask(
    input logic [1:0] len
  );
    logic [7:0] m;
    case (len)
      LEN_5: m = 8'h1f;
      LEN_6: m = 8'h3f;
      LEN_7: m = 8'h7f;
      LEN_8: m = 8'hff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dti_uart_baud_gen.sv
// dti_uart_baud_gen: oversample tick generator,
// one tick every cfg_div+1 clocks.
module dti_uart_baud_gen #(
  parameter int DIV_W = dti_uart_pkg::DIV_W_DEF
) (
  input  logic             uart_clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             wrap;

  // Compare before incrementing so all-ones never overflows
  always_comb begin
    wrap  = (cnt_q >= cfg_div);
    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    if (clear) begin
      cnt_d = '0;
    end
  end

  assign tick = wrap & ~clear;

  always_ff @(posedge uart_clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dti_uart_tx.sv
// dti_uart_tx: UART transmitter with configurable
// length, parity and stop bits; 16x oversampled timing.
module dti_uart_tx #(
  parameter int DIV_W = dti_uart_pkg::DIV_W_DEF,
  parameter int OVS   = dti_uart_pkg::OVS
) (
  input  logic             uart_clk,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  logic             cfg_parity_en,
  input  logic             cfg_parity_odd,
  input  logic             cfg_stop2,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             txd,
  output logic             tx_busy
);

  import dti_uart_pkg::*;

  localparam int OVS_W = $clog2(OVS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS - 1);

  uart_state_e      state_q, state_d;
  logic             txd_q, txd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [OVS_W-1:0] ovs_q, ovs_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       len_q, len_d;
  logic             pen_q, pen_d;
  logic             par_q, par_d;
  logic             s2_q, s2_d;

  logic             accept;
  logic             tick;
  logic             bit_end;
  logic [2:0]       last_bit;
  logic [7:0]       data_m;

  assign accept   = tx_valid & ready_q;
  assign bit_end  = tick & (ovs_q == OVS_LAST);
  assign last_bit = 3'd4 + {1'b0, len_q};

  dti_uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud (
    .uart_clk (uart_clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .cfg_div  (div_q),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    ovs_d   = ovs_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    div_d   = div_q;
    len_d   = len_q;
    pen_d   = pen_q;
    par_d   = par_q;
    s2_d    = s2_q;
    data_m  = tx_data & len_mask(cfg_data_bits);

    if (tick) begin
      ovs_d = (ovs_q == OVS_LAST) ? '0 : ovs_q + OVS_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        txd_d   = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          state_d = ST_START;
          txd_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          ovs_d   = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          sh_d    = data_m;
          div_d   = cfg_div;
          len_d   = cfg_data_bits;
          pen_d   = cfg_parity_en;
          par_d   = (^data_m) ^ cfg_parity_odd;
          s2_d    = cfg_stop2;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          txd_d   = sh_q[0];
          sh_d    = sh_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == last_bit) begin
            state_d = pen_q ? ST_PARITY : ST_STOP;
            txd_d   = pen_q ? par_q : 1'b1;
          end else begin
            txd_d = sh_q[0];
            sh_d  = sh_q >> 1;
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (s2_q && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      txd_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ovs_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      div_q   <= '0;
      len_q   <= '0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      s2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ovs_q   <= ovs_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      div_q   <= div_d;
      len_q   <= len_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      s2_q    <= s2_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;

endmodule

// File: doc/dti_uart_tx.md
DTI_UART_TX -- requirements
Module: dti_uart_tx

Interface
REQ-001 Parameter: DIV_W, default 16, width of baud divisor.
REQ-002 Parameter: OVS, default 16, oversample ticks per bit; fixed at 16 in this release.
REQ-003 uart_clk  input  1  single clock; all logic rises on posedge uart_clk.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 cfg_div  input  DIV_W  baud divisor; one oversample tick every cfg_div+1 uart_clk cycles.
REQ-006 cfg_data_bits  input  2  character length: 00=5, 01=6, 10=7, 11=8 bits.
REQ-007 cfg_parity_en  input  1  1 = append parity bit.
REQ-008 cfg_parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-009 cfg_stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-010 tx_data  input  8  character to send, LSB first; bits above the configured length are ignored.
REQ-011 tx_valid  input  1  upstream has a character.
REQ-012 tx_ready  output  1  block accepts a character this cycle.
REQ-013 txd  output  1  serial line; idle high.
REQ-014 tx_busy  output  1  frame in progress (START through last STOP).

Function
REQ-015 Transfer occurs on a cycle with tx_valid=1 and tx_ready=1; tx_data and all cfg_* inputs are latched on that cycle.
REQ-016 cfg_* changes after the accept cycle have no effect on the frame in flight.
REQ-017 tx_ready is registered; it is 1 only in IDLE and drops on the cycle after accept.
REQ-018 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-019 Transitions: IDLE->START on accept; START->DATA after 1 bit time; DATA->PARITY (parity enabled) or ->STOP after the configured number of data bits; PARITY->STOP after 1 bit time; STOP->IDLE after 1 or 2 bit times.
REQ-020 Bit time is exactly OVS*(cfg_div+1) uart_clk cycles. cfg_div=0 gives 16 cycles per bit.
REQ-021 The baud tick counter and the oversample counter clear on the accept cycle, so the start bit is a full bit time.
REQ-022 txd is registered. It goes 0 on the cycle after accept (latency 1).
REQ-023 txd drives: 0 in START, data LSB first in DATA, the parity bit in PARITY, 1 in STOP and IDLE.
REQ-024 Even parity is the XOR of the configured data bits only. Odd parity is its inverse.
REQ-025 Back-to-back frames: with tx_valid held, the next start bit follows the last stop bit after exactly 1 extra idle cycle (the IDLE cycle holding tx_ready=1).
REQ-026 tx_valid=1 while not in IDLE is ignored. Upstream data is not consumed until tx_ready=1.
REQ-027 The tick counter wraps to 0 on reaching cfg_div. At cfg_div = all-ones it must not overflow or stall.
REQ-028 tx_busy is 1 from the cycle txd first goes 0 through the final cycle of the last stop bit.

Reset
REQ-029 While reset_n=0 at a clock edge: state=IDLE, txd=1, tx_ready=0, tx_busy=0, all counters=0.
REQ-030 tx_ready goes to 1 on the first clock edge with reset_n=1.
REQ-031 Reset asserted mid-frame aborts the frame. txd returns to 1 on that edge and no partial frame resumes.

Structure
REQ-032 Shared package dti_uart_pkg holds: the state enum typedef, data-length encoding constants, OVS, and the DIV_W default.
REQ-033 Sub-module dti_uart_baud_gen (ports: uart_clk, reset_n, clear, cfg_div, tick) produces the oversample tick. It is reused by the future RX block.
REQ-034 The TX shift/FSM logic lives in dti_uart_tx. Target size is 150-300 lines of RTL total.

Verification
REQ-035 Reset release, tx_valid=0: txd=1 and tx_busy=0 throughout; tx_ready=1 from the first post-reset cycle.
REQ-036 cfg_div=0, 8N1, tx_data=0xA5 -> txd=0 for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then 1 for 16 cycles; tx_ready returns 1 cycle 161 after accept.
REQ-037 cfg_div=2, 7E2, tx_data=0x53 -> bit time 48 cycles, 7 data bits 1,1,0,0,1,0,1, parity=0, two stop bits of 48 cycles each.
REQ-038 5O1, tx_data=0xFF -> data 1,1,1,1,1 (upper bits ignored), parity=0; cfg change during DATA leaves the frame unchanged.
REQ-039 tx_valid held with 3 queued characters at cfg_div=0, 8N1 -> exactly 1 idle cycle between each last stop bit and the next start bit; every character is accepted exactly once.
REQ-040 reset_n=0 in the middle of the DATA state -> txd=1 and tx_busy=0 on that edge; after release, the next frame starts clean with a full-length start bit.
